uart_rx_port: RTL and testbench
===============================

Name: uart_rx_port

Overview:
- CPU-readable serial input port: the input-direction counterpart of the write-only io_port latch.
- Deserialises an 8N1 async line into an 8-entry FIFO; exposes a data register and a status register on the 65C02 bus.
- Top level decodes the address window and drives read as the address-decoded, ~cpu_clk-qualified strobe, exactly as for vdp_read.
- Top level captures data_out into the CPU data-in mux register.

Parameters:
CLKS_PER_BIT, 547, system clocks per bit (63 MHz / 115200); minimum 8
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW

Ports:
clk  input  1  63 MHz system clock
reset  input  1  asynchronous, active-high; clears all state
rx  input  1  serial line, idle high, asynchronous to clk
read  input  1  bus read strobe, level; held for many clk cycles per CPU access
addr  input  1  register select: 0 = data, 1 = status
data_out  output  8  registered read data
data_ready  output  1  high while FIFO non-empty

Behaviour:
- Reset values:
  - data_out = 0x00, data_ready = 0.
  - FIFO empty; sticky flags clear; FSM in IDLE.
  - Synchroniser flops = 1.
- Input: rx passes through a 2-flop synchroniser. All decisions use the synchronised value rxs.
- Bit counter: counts clk cycles within a bit. Bit index: 0..7.
- FSM IDLE:
  - rxs low -> START.
  - On entry to START, load counter with CLKS_PER_BIT/2 - 1 (integer divide).
- FSM START:
  - Counter reaches 0: if rxs = 0 -> DATA with counter = CLKS_PER_BIT-1, index = 0.
  - Otherwise (glitch) -> IDLE; nothing recorded.
- FSM DATA:
  - Each time counter reaches 0, shift rxs into bit [index], LSB first.
  - Reload counter with CLKS_PER_BIT-1.
  - After index 7 -> STOP.
- FSM STOP:
  - Counter reaches 0 (mid stop bit), rxs = 1: push byte on that clk -> IDLE.
  - rxs = 0: set FERR, discard byte -> BREAK.
- FSM BREAK: wait for rxs = 1, then -> IDLE.
- Push timing: byte is visible (data_ready = 1) on the clk after the stop-bit sample.
- Push when FIFO full: byte dropped, OVR set.
  - Exception: a pop in the same clk makes room; the push is then accepted.
- Read access, edge-detected:
  - A pop or flag-clear happens only on the first clk where read = 1 after read = 0 (rising edge of an internal registered copy).
  - On that clk, data_out is loaded with the selected register.
  - data_out holds its value until the next read rising edge.
  - Holding read high for any number of clks produces exactly one pop.
- Data register (addr 0):
  - Returns the FIFO head and pops it.
  - When empty: returns 0x00, no pop, no pointer change.
- Status register (addr 1):
  - bit0 = not empty, bit1 = full, bit2 = OVR (sticky), bit3 = FERR (sticky), bits7:4 = 0.
  - The value is captured first; OVR and FERR are then cleared on the same clk.
  - A flag-setting event on that same clk wins: the flag stays set.
- Simultaneous push and pop: both occur; occupancy unchanged; pointers wrap modulo depth.
- Occupancy counter: FIFO_AW+1 bits. full = (count == 2**FIFO_AW).
- data_ready = (count != 0), registered with the count.
- Reset asserted mid-frame or mid-read:
  - Immediate return to reset values; partial byte discarded.
  - After release, the next start bit is received normally.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 8N1:
  - data_ready rises one clk after the stop-bit mid sample.
  - Status read = 0x01; data read = 0xA5; then status = 0x00, data_ready = 0.
- Queue 0x11, 0x22, then hold read (addr 0) high for 8 clks:
  - data_out = 0x11 and stays stable; count drops by exactly 1.
  - Second strobe returns 0x22; third returns 0x00 with count still 0.
- Send 9 bytes 0x01..0x09 with no reads:
  - Status = 0x07.
  - Eight data reads return 0x01..0x08; 0x09 is lost.
  - Following status read = 0x00.
- Frame 0x5A with stop bit driven 0, line held low 40 clks, then high:
  - No push; status = 0x08 then 0x00.
  - Next frame 0x3C received correctly.
- rx low pulse of 5 clks (< half bit) from IDLE: FSM returns to IDLE, no push, status = 0x00.
- Assert reset during bit 4 of a frame:
  - data_out = 0x00, data_ready = 0, FIFO empty.
  - After release, 0xC3 is received and read back correctly.
- Push while full with a same-clk data pop: byte accepted, OVR stays 0, count stays 8.

Source files
------------

// File: rtl/uart_rx_port.sv
// uart_rx_port: CPU-readable 8N1 serial receive port with an 8-entry FIFO.
//
// A 2-flop synchroniser feeds a mid-bit sampling receiver. Received bytes go
// into a FIFO. The CPU can read two registers. Each read is edge-detected, so
// only the first clk of a read strobe has any side effect.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high; clears all state
//   rx         serial line, idle high, asynchronous to clk
//   read       bus read strobe (level, held for many clks per access)
//   addr       register select: 0 = data (pops FIFO head), 1 = status
//   data_out   registered read data, loaded on the read rising edge
//   data_ready high while the FIFO is non-empty
//
// Status register: bit0 not empty, bit1 full, bit2 OVR (sticky),
//                  bit3 FERR (sticky), bits 7:4 zero.
module uart_rx_port #(
   parameter int unsigned CLKS_PER_BIT = 547,
   parameter int unsigned FIFO_AW      = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       read,
   input  logic       addr,
   output logic [7:0] data_out,
   output logic       data_ready
);

   localparam int unsigned DEPTH = 2 ** FIFO_AW;
   localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]      FULL_LD = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]      HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [FIFO_AW:0]   CNT_MAX = {1'b1, {FIFO_AW{1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t           state, state_nx;
   logic             rx_s1, rxs;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [2:0]       idx, idx_nx;
   logic [7:0]       shreg, shreg_nx;
   logic             push, ferr_set;

   logic [7:0]       mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0] count, count_nx;
   logic             full, empty, push_ok, pop, ovr_set;
   logic             ovr, ferr, read_q, rd_edge;
   logic [7:0]       status;

   // Synchroniser and receiver state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_s1 <= 1'b1;
         rxs   <= 1'b1;
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         rx_s1 <= rx;
         rxs   <= rx_s1;
         state <= state_nx;
         cnt   <= cnt_nx;
         idx   <= idx_nx;
         shreg <= shreg_nx;
      end
   end

   // Receiver next-state logic. Each bit is sampled when the counter hits 0.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      shreg_nx = shreg;
      push     = 1'b0;
      ferr_set = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!rxs) begin
               state_nx = S_START;
               cnt_nx   = HALF_LD;
            end
         end
         S_START: begin
            if (cnt == '0) begin
               if (!rxs) begin
                  state_nx = S_DATA;
                  cnt_nx   = FULL_LD;
                  idx_nx   = '0;
               end else begin
                  state_nx = S_IDLE;
               end
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         S_DATA: begin
            if (cnt == '0) begin
               shreg_nx[idx] = rxs;
               cnt_nx        = FULL_LD;
               if (idx == 3'd7) state_nx = S_STOP;
               else             idx_nx   = idx + 3'd1;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         S_STOP: begin
            if (cnt == '0) begin
               if (rxs) begin
                  push     = 1'b1;
                  state_nx = S_IDLE;
               end else begin
                  ferr_set = 1'b1;
                  state_nx = S_BREAK;
               end
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         S_BREAK: begin
            if (rxs) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // FIFO and bus interface
   assign empty   = (count == '0);
   assign full    = (count == CNT_MAX);
   assign rd_edge = read & ~read_q;
   assign pop     = rd_edge & ~addr & ~empty;
   // A pop on the same clk frees a slot, so a push into a full FIFO still lands.
   assign push_ok = push & (~full | pop);
   assign ovr_set = push & full & ~pop;
   assign status  = {4'b0000, ferr, ovr, full, ~empty};

   always_comb begin
      count_nx = count;
      unique case ({push_ok, pop})
         2'b10:   count_nx = count + (FIFO_AW + 1)'(1);
         2'b01:   count_nx = count - (FIFO_AW + 1)'(1);
         default: count_nx = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         data_ready <= 1'b0;
         ovr        <= 1'b0;
         ferr       <= 1'b0;
         read_q     <= 1'b0;
         data_out   <= '0;
      end else begin
         read_q     <= read;
         count      <= count_nx;
         data_ready <= (count_nx != '0);
         if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
         // Setting events win over the status-read clear on the same clk.
         if (ovr_set)             ovr <= 1'b1;
         else if (rd_edge & addr) ovr <= 1'b0;
         if (ferr_set)            ferr <= 1'b1;
         else if (rd_edge & addr) ferr <= 1'b0;
         if (rd_edge) begin
            if (addr)       data_out <= status;
            else if (empty) data_out <= '0;
            else            data_out <= mem[rd_ptr];
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_port.sv
// tb_uart_rx_port: scoreboard bench for uart_rx_port with CLKS_PER_BIT=16.
// The stimulus side keeps a byte-queue model of the port. It pushes the
// expected read data into exp_q. A monitor compares data_out after each read
// rising edge and checks that data_out stays stable while read is held.
module tb_uart_rx_port;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset, rx, read, addr;
   logic [7:0] data_out;
   logic       data_ready;

   uart_rx_port #(.CLKS_PER_BIT(CPB), .FIFO_AW(3)) dut (
      .clk(clk), .reset(reset), .rx(rx), .read(read), .addr(addr),
      .data_out(data_out), .data_ready(data_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } chk_t;

   chk_t       dq[$];
   logic [7:0] exp_q[$];
   int         vectors = 0;
   int         miscompares = 0;

   // Reference model: received bytes and the two sticky flags
   logic [7:0] mq[$];
   bit         m_ovr = 0, m_ferr = 0;

   // Monitor: all counting happens here
   bit         read_prev = 0, pend = 0, holding = 0;
   logic [7:0] hold_val = '0;
   chk_t       c;
   logic [7:0] e;

   always @(negedge clk) begin
      while (dq.size() > 0) begin
         c = dq.pop_front();
         vectors++;
         if (c.act !== c.exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, c.act, c.exp);
         end
      end
      if (pend) begin
         pend = 0;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL rd_unexpected: got 0x%0h expected no read", data_out);
         end else begin
            e = exp_q.pop_front();
            if (data_out !== e) begin
               miscompares++;
               $display("FAIL rd_data: got 0x%0h expected 0x%0h", data_out, e);
            end
            hold_val = e;
            holding  = 1;
         end
      end else if (holding && read) begin
         vectors++;
         if (data_out !== hold_val) begin
            miscompares++;
            $display("FAIL rd_hold_stable: got 0x%0h expected 0x%0h", data_out, hold_val);
         end
      end
      if (!read) holding = 0;
      if (read && !read_prev) pend = 1;
      read_prev = read;
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      chk_t t;
      t.name = n;
      t.act  = a;
      t.exp  = x;
      dq.push_back(t);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive a frame (start, 8 data LSB first, stop). Slots past the stop bit
   // take the value tail. The return value is the number of clks from the
   // start-bit drive to the data_ready rise, or -1 if it did not rise.
   // If pop_at >= 0, a data read strobe is raised at that clk.
   task automatic drive_line(input logic [7:0] b, input logic stopb, input logic tail,
                             input int ncyc, input int pop_at, output int rise_k);
      logic [9:0] frame;
      logic       prev;
      int         slot;
      frame  = {stopb, b, 1'b0};
      rise_k = -1;
      prev   = data_ready;
      for (int k = 0; k < ncyc; k++) begin
         slot = k / CPB;
         rx   = (slot < 10) ? frame[slot] : tail;
         if (k == pop_at) begin
            addr = 1'b0;
            read = 1'b1;
         end
         tick(1);
         if (rise_k < 0 && !prev && data_ready) rise_k = k + 1;
         prev = data_ready;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stopb, output int rise_k);
      if (stopb) begin
         drive_line(b, 1'b1, 1'b1, 10 * CPB, -1, rise_k);
         if (mq.size() == 8) m_ovr = 1;
         else                mq.push_back(b);
      end else begin
         // Bad stop bit: keep the line low for 40 clks from the stop-bit start
         drive_line(b, 1'b0, 1'b0, 9 * CPB + 40, -1, rise_k);
         rx = 1'b1;
         m_ferr = 1;
      end
      tick(4);
   endtask

   task automatic read_reg(input logic a, input int hold);
      logic [7:0] x;
      if (a) begin
         x = {4'b0000, m_ferr, m_ovr, mq.size() == 8, mq.size() != 0};
         m_ovr  = 0;
         m_ferr = 0;
      end else if (mq.size() == 0) begin
         x = 8'h00;
      end else begin
         x = mq.pop_front();
      end
      exp_q.push_back(x);
      addr = a;
      read = 1'b1;
      tick(hold);
      read = 1'b0;
      tick(3);
   endtask

   int rk;

   initial begin
      reset = 1'b1;
      rx    = 1'b1;
      read  = 1'b0;
      addr  = 1'b0;
      tick(3);
      chk("reset_data_out", data_out, 8'h00);
      chk("reset_data_ready", data_ready, 0);
      reset = 1'b0;
      tick(3);
      read_reg(1, 2);

      // Single byte: data_ready rises one clk after the mid stop-bit sample.
      // That is 2 sync + 1 detect + CPB/2 start + 9*CPB clks after the start bit.
      send_byte(8'hA5, 1'b1, rk);
      chk("ready_rise_clk", rk, 2 + 1 + CPB / 2 + 9 * CPB);
      read_reg(1, 2);
      read_reg(0, 2);
      read_reg(1, 2);
      chk("ready_low_after_drain", data_ready, 0);

      // A long read strobe pops exactly once
      send_byte(8'h11, 1'b1, rk);
      send_byte(8'h22, 1'b1, rk);
      read_reg(0, 8);
      read_reg(0, 8);
      read_reg(0, 8);
      read_reg(1, 2);

      // Overflow: 9 bytes into an 8-deep FIFO
      for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1, rk);
      read_reg(1, 2);
      for (int i = 0; i < 8; i++) read_reg(0, 2);
      read_reg(1, 2);

      // Short glitch from idle is rejected
      rx = 1'b0;
      tick(5);
      rx = 1'b1;
      tick(30);
      read_reg(1, 2);
      chk("glitch_no_push", data_ready, 0);

      // Framing error followed by break, then a good frame
      send_byte(8'h5A, 1'b0, rk);
      tick(10);
      read_reg(1, 2);
      read_reg(1, 2);
      send_byte(8'h3C, 1'b1, rk);
      read_reg(0, 2);

      // Reset in bit 4 of a frame
      drive_line(8'h5F, 1'b1, 1'b1, 5 * CPB + 8, -1, rk);
      reset = 1'b1;
      rx    = 1'b1;
      tick(3);
      chk("midframe_rst_data_out", data_out, 8'h00);
      chk("midframe_rst_ready", data_ready, 0);
      reset = 1'b0;
      mq.delete();
      m_ovr  = 0;
      m_ferr = 0;
      tick(20);
      read_reg(1, 2);
      send_byte(8'hC3, 1'b1, rk);
      read_reg(0, 2);

      // Push into a full FIFO with a data pop on the stop-sample clk
      for (int i = 0; i < 8; i++) send_byte(8'h80 + 8'(i), 1'b1, rk);
      exp_q.push_back(mq.pop_front());
      drive_line(8'hE7, 1'b1, 1'b1, 10 * CPB, 2 + 1 + CPB / 2 + 9 * CPB - 1, rk);
      mq.push_back(8'hE7);
      read = 1'b0;
      tick(4);
      read_reg(1, 2);
      for (int i = 0; i < 8; i++) read_reg(0, 2);
      read_reg(1, 2);

      // Randomised traffic with interleaved register reads
      for (int i = 0; i < 24; i++) begin
         send_byte(8'($urandom), ($urandom_range(0, 7) != 0), rk);
         for (int r = $urandom_range(0, 2); r > 0; r--)
            read_reg(1'($urandom_range(0, 1)), $urandom_range(1, 6));
      end
      read_reg(1, 2);
      while (mq.size() > 0) read_reg(0, $urandom_range(1, 4));
      read_reg(1, 2);
      chk("final_ready", data_ready, 0);

      chk("scoreboard_drained", exp_q.size(), 0);
      tick(3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
